ps2_note_decoder: RTL

PS2_NOTE_DECODER -- requirements
Module: ps2_note_decoder

---
 rtl/ps2_note_decoder_if.sv | 22 ++
 rtl/ps2_note_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder_if.sv
// PS/2 scancode-in / note-out bundle between the keyboard front end and the
// note decoder.
interface ps2_note_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic [4:0] note;
  logic       gate;
  logic       note_on;
  logic [7:0] held_code;

  // Byte source side, which also observes the decoder outputs
  modport master (
    output ps2_byte, ps2_byte_en,
    input  note, gate, note_on, held_code
  );

  // Decoder side
  modport slave (
    input  ps2_byte, ps2_byte_en,
    output note, gate, note_on, held_code
  );
endinterface

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: parses PS/2 set-2 make/break/extended sequences and turns
// a one-octave key row into a last-key-priority monophonic note with gate.
// Optional feature macro: PS2_NOTE_OCTAVE_EN enables '-' / '=' octave select.
module ps2_note_decoder (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  ps2_note_decoder_if.slave    bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NOTE_W = 5;
  localparam int unsigned IDX_W  = 4;

  localparam logic [BYTE_W-1:0] CODE_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] CODE_EXT   = 8'hE0;
`ifdef PS2_NOTE_OCTAVE_EN
  localparam logic [BYTE_W-1:0] CODE_OCT_LO = 8'h4E;
  localparam logic [BYTE_W-1:0] CODE_OCT_HI = 8'h55;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t             state;
  logic [NOTE_W-1:0]  note_q;
  logic               gate_q;
  logic               note_on_q;
  logic [BYTE_W-1:0]  held_q;

`ifdef PS2_NOTE_OCTAVE_EN
  logic [NOTE_W-1:0]  offset_q;
`else
  localparam logic [NOTE_W-1:0] offset_q = 5'd0;
`endif

  logic               map_hit;
  logic [IDX_W-1:0]   map_idx;
  logic               make_latch;
  logic               brk_release;

  // Scancode to semitone lookup for the playable key row
  always_comb begin
    map_hit = 1'b1;
    map_idx = 4'd0;
    unique case (bus.ps2_byte)
      8'h1C:   map_idx = 4'd0;
      8'h1D:   map_idx = 4'd1;
      8'h1B:   map_idx = 4'd2;
      8'h24:   map_idx = 4'd3;
      8'h23:   map_idx = 4'd4;
      8'h2B:   map_idx = 4'd5;
      8'h2C:   map_idx = 4'd6;
      8'h34:   map_idx = 4'd7;
      8'h35:   map_idx = 4'd8;
      8'h33:   map_idx = 4'd9;
      8'h3C:   map_idx = 4'd10;
      8'h3B:   map_idx = 4'd11;
      8'h42:   map_idx = 4'd12;
      default: map_hit = 1'b0;
    endcase
  end

  // A held key repeating (typematic) never retriggers; mapped codes are never
  // 0x00, so comparing against held_q also covers the nothing-held case.
  always_comb begin
    make_latch  = map_hit && (bus.ps2_byte != held_q);
    brk_release = gate_q && (bus.ps2_byte == held_q);
  end

  // Parse FSM plus registered note/gate/held outputs
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      note_q    <= '0;
      gate_q    <= 1'b0;
      note_on_q <= 1'b0;
      held_q    <= 8'h00;
`ifdef PS2_NOTE_OCTAVE_EN
      offset_q  <= '0;
`endif
    end else begin
      note_on_q <= 1'b0;
      if (bus.ps2_byte_en) begin
        unique case (state)
          ST_IDLE: begin
            if (bus.ps2_byte == CODE_BREAK) begin
              state <= ST_BRK;
            end else if (bus.ps2_byte == CODE_EXT) begin
              state <= ST_EXT;
            end else begin
`ifdef PS2_NOTE_OCTAVE_EN
              if (bus.ps2_byte == CODE_OCT_LO) offset_q <= 5'd0;
              if (bus.ps2_byte == CODE_OCT_HI) offset_q <= 5'd12;
`endif
              if (make_latch) begin
                note_q    <= NOTE_W'(map_idx) + offset_q;
                gate_q    <= 1'b1;
                held_q    <= bus.ps2_byte;
                note_on_q <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            // Repeated 0xF0 keeps waiting for the code being released
            if (bus.ps2_byte != CODE_BREAK) begin
              state <= ST_IDLE;
              if (brk_release) begin
                gate_q <= 1'b0;
                held_q <= 8'h00;
              end
            end
          end
          ST_EXT: begin
            state <= (bus.ps2_byte == CODE_BREAK) ? ST_EXT_BRK : ST_IDLE;
          end
          ST_EXT_BRK: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.note      = note_q;
  assign bus.gate      = gate_q;
  assign bus.note_on   = note_on_q;
  assign bus.held_code = held_q;

endmodule
